// File: rtl/i2s_capture_fifo.sv
// I2S single-channel capture into a show-ahead FIFO with valid/ready output and overflow counting.
// Optional peak level meter (o_peak / i_peak_clr) is built when LEVEL_METER_EN is defined.
module i2s_capture_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CHANNEL    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_ADCLRCK,
  input  logic              i_ADCDAT,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_overflow_cnt,
  output logic              o_busy,
  output logic [1:0]        o_state
`ifdef LEVEL_METER_EN
  ,
  output logic [DATA_W-2:0] o_peak,
  input  logic              i_peak_clr
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic CH_LEVEL = (CHANNEL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SKIP  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              lrck_prev, lrck_edge, chan_start;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              shift_en, push_set, push_pend;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [7:0]        ovf_cnt;
  logic              empty, full, pop, push, drop;

  assign lrck_edge  = (lrck_prev != i_ADCLRCK);
  assign chan_start = lrck_edge && (i_ADCLRCK == CH_LEVEL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    shift_en   = 1'b0;
    push_set   = 1'b0;
    if (!i_enable) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_next = S_WAIT;
        S_WAIT:  if (chan_start) state_next = S_SKIP;
        S_SKIP:  state_next = S_SHIFT;
        S_SHIFT: begin
          // The final bit completes the word even if LRCK moves on that same cycle.
          if (bit_cnt == CW'(DATA_W - 1)) begin
            shift_en   = 1'b1;
            push_set   = 1'b1;
            state_next = chan_start ? S_SKIP : S_WAIT;
          end else if (lrck_edge) begin
            state_next = chan_start ? S_SKIP : S_WAIT;
          end else begin
            shift_en = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      lrck_prev <= i_ADCLRCK;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
      state     <= state_next;
      lrck_prev <= i_ADCLRCK;
      push_pend <= push_set;
      if (state == S_SKIP) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {shreg[DATA_W-2:0], i_ADCDAT};
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && i_ready;
  assign push  = push_pend && (!full || pop);
  assign drop  = push_pend && full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_cnt <= '0;
      // NOTE: storage is reset because the head entry is visible on o_data straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign o_data         = mem[rd_ptr[AW-1:0]];
  assign o_valid        = !empty;
  assign o_overflow_cnt = ovf_cnt;
  assign o_busy         = (state == S_SKIP) || (state == S_SHIFT);
  assign o_state        = state;

`ifdef LEVEL_METER_EN
  logic [DATA_W-1:0] neg;
  logic [DATA_W-2:0] mag, peak;

  // Magnitude of the captured word; the most negative code saturates to the largest positive one.
  assign neg = (~shreg) + DATA_W'(1);
  assign mag = !shreg[DATA_W-1] ? shreg[DATA_W-2:0]
             : (neg[DATA_W-1] ? '1 : neg[DATA_W-2:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        peak <= '0;
    else if (i_peak_clr)              peak <= '0;
    else if (push_pend && mag > peak) peak <= mag;
  end

  assign o_peak = peak;
`endif

endmodule

// File: tb/tb_i2s_capture_fifo.sv
// Randomized self-checking bench for i2s_capture_fifo against a transaction-level FIFO model.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_i2s_capture_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, enable, lrck, dat, ready;
  logic [DW-1:0] data;
  logic          valid, busy;
  logic [7:0]    ovf;
  logic [1:0]    state;
`ifdef LEVEL_METER_EN
  logic [DW-2:0] peak;
  logic          peak_clr;
`endif

  int            vectors = 0, miscompares = 0;
  int            valid_cycles = 0;
  int            exp_ovf = 0;
  bit            rand_ready = 1'b0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_capture_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CHANNEL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .i_ADCLRCK(lrck), .i_ADCDAT(dat),
    .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_overflow_cnt(ovf), .o_busy(busy), .o_state(state)
`ifdef LEVEL_METER_EN
    , .o_peak(peak), .i_peak_clr(peak_clr)
`endif
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) valid_cycles++;
      if (valid && ready) got_q.push_back(data);
    end
  end

  // Reference model: a word captured while nobody drains is kept if the FIFO has room, else counted.
  function automatic void model_push(input logic [DW-1:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else if (exp_ovf < 255) exp_ovf++;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic l, input logic d);
    lrck = l;
    dat  = d;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  // One LRCK half: edge cycle, I2S delay bit, then nbits MSB-first, padded to slot cycles.
  task automatic send_half(input logic level, input logic [DW-1:0] word, input int nbits, input int slot);
    for (int c = 0; c < slot; c++) begin
      if (c >= 2 && c < nbits + 2) drive(level, word[DW+1-c]);
      else drive(level, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] lw, input int slot = 20);
    send_half(1'b0, lw, DW, slot);
    send_half(1'b1, DW'($urandom), DW, slot);
  endtask

  task automatic drain(input int n);
    ready = 1'b1;
    repeat (n) drive(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", data); end
    vectors++; if (ovf !== 8'd0) begin miscompares++; $display("FAIL reset_ovf: got %0d want 0", ovf); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    ready  = 1'b1;
    repeat (3) drive(1'b1, 1'b0);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL reset_to_wait: got %0d want 1", state); end
  endtask

  task automatic test_basic();
    got_q.delete();
    valid_cycles = 0;
    ready = 1'b1;
    send_half(1'b0, 16'hA5C3, DW, 18);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_at_lsb: got %b want 0", valid); end
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL basic_state_after: got %0d want 1", state); end
    drive(1'b1, 1'b1);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_next: got %b want 1", valid); end
    vectors++; if (data !== 16'hA5C3) begin miscompares++; $display("FAIL basic_data: got %h want a5c3", data); end
    drive(1'b1, 1'b1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop: got %b want 0", valid); end
    repeat (18) drive(1'b1, 1'b1);
    vectors++; if (valid_cycles !== 1) begin miscompares++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles); end
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin
      miscompares++; $display("FAIL basic_transfers: got %0d words want 1 (a5c3)", got_q.size());
    end
  endtask

  task automatic test_overflow();
    got_q.delete();
    exp_q.delete();
    ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      send_frame(DW'(k));
      model_push(DW'(k));
    end
    vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL ovf_count: got %0d want %0d", ovf, exp_ovf); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid_full: got %b want 1", valid); end
    drain(10);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL ovf_drain_len: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got %b want 0", valid); end
  endtask

  task automatic test_hold_random();
    repeat (2) begin
      int n;
      logic [DW-1:0] w;
      got_q.delete();
      exp_q.delete();
      ready = 1'b0;
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        w = DW'($urandom);
        send_frame(w);
        model_push(w);
      end
      vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL hold_ovf n=%0d: got %0d want %0d", n, ovf, exp_ovf); end
      drain(10);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL hold_len: got %0d want %0d", got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < got_q.size(); i++) begin
          vectors++;
          if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL hold[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [DW-1:0] w[5];
    got_q.delete();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) send_frame(w[i]);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ppf_full_valid: got %b want 1", valid); end
    send_half(1'b0, w[4], DW, 18);
    ready = 1'b1;
    send_half(1'b1, DW'($urandom), DW, 20);
    drain(8);
    vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL ppf_ovf: got %0d want %0d", ovf, exp_ovf); end
    vectors++;
    if (got_q.size() != 5) begin
      miscompares++; $display("FAIL ppf_len: got %0d want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (got_q[i] !== w[i]) begin miscompares++; $display("FAIL ppf[%0d]: got %h want %h", i, got_q[i], w[i]); end
      end
    end
  endtask

  task automatic test_disable();
    logic [DW-1:0] wa, wb;
    got_q.delete();
    wa = DW'($urandom);
    wb = DW'($urandom);
    ready = 1'b0;
    send_frame(wa);
    for (int c = 0; c < 20; c++) begin
      if (c == 9) enable = 1'b0;
      drive(1'b0, 1'($urandom_range(0, 1)));
    end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL dis_state: got %0d want 0", state); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL dis_busy: got %b want 0", busy); end
    vectors++; if (valid !== 1'b1 || data !== wa) begin miscompares++; $display("FAIL dis_retain: got %b/%h want 1/%h", valid, data, wa); end
    ready = 1'b1;
    send_half(1'b1, DW'($urandom), DW, 20);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) enable = 1'b1;
      drive(1'b0, 1'($urandom_range(0, 1)));
    end
    send_half(1'b1, DW'($urandom), DW, 20);
    send_frame(wb);
    vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL dis_ovf: got %0d want %0d", ovf, exp_ovf); end
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++; $display("FAIL dis_len: got %0d want 2", got_q.size());
    end else begin
      vectors++; if (got_q[0] !== wa) begin miscompares++; $display("FAIL dis_drain: got %h want %h", got_q[0], wa); end
      vectors++; if (got_q[1] !== wb) begin miscompares++; $display("FAIL dis_recapture: got %h want %h", got_q[1], wb); end
    end
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] w;
    got_q.delete();
    valid_cycles = 0;
    ready = 1'b1;
    w = DW'($urandom);
    send_half(1'b0, DW'($urandom), 10, 12);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL short_busy: got %b want 1", busy); end
    drive(1'b1, 1'b0);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL short_abort_state: got %0d want 1", state); end
    repeat (19) drive(1'b1, 1'($urandom_range(0, 1)));
    vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL short_no_valid: got %0d want 0", valid_cycles); end
    send_frame(w);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== w) begin
      miscompares++; $display("FAIL short_next: got %0d words want 1 (%h)", got_q.size(), w);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] corners[4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    logic [DW-1:0] w;
    int nb;
    got_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    repeat (12) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = $urandom_range(1, 14);
        send_half(1'b0, DW'($urandom), nb, nb + 2);
        send_half(1'b1, DW'($urandom), DW, 20);
      end
      w = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
      send_frame(w, $urandom_range(18, 24));
      exp_q.push_back(w);
    end
    rand_ready = 1'b0;
    drain(10);
    vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL rand_ovf: got %0d want %0d", ovf, exp_ovf); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_len: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

`ifdef LEVEL_METER_EN
  function automatic int magnitude(input logic [DW-1:0] w);
    int v;
    v = $signed(w);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic test_peak();
    logic [DW-1:0] seq[3] = '{16'h1234, 16'h8000, 16'h0100};
    int exp_peak;
    ready = 1'b1;
    peak_clr = 1'b1;
    drive(1'b1, 1'b0);
    peak_clr = 1'b0;
    vectors++; if (peak !== '0) begin miscompares++; $display("FAIL peak_clr0: got %h want 0000", peak); end
    exp_peak = 0;
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i]);
      if (magnitude(seq[i]) > exp_peak) exp_peak = magnitude(seq[i]);
    end
    vectors++; if (peak !== (DW-1)'(exp_peak)) begin miscompares++; $display("FAIL peak_max: got %h want %h", peak, exp_peak); end
    peak_clr = 1'b1;
    drive(1'b1, 1'b0);
    peak_clr = 1'b0;
    send_frame(16'hFF00);
    exp_peak = magnitude(16'hFF00);
    vectors++; if (peak !== (DW-1)'(exp_peak)) begin miscompares++; $display("FAIL peak_after_clr: got %h want %h", peak, exp_peak); end
  endtask
`endif

  task automatic test_saturate();
    logic [DW-1:0] w;
    got_q.delete();
    exp_q.delete();
    ready = 1'b0;
    repeat (260) begin
      w = DW'($urandom);
      send_frame(w, 18);
      model_push(w);
    end
    vectors++; if (ovf !== 8'(exp_ovf)) begin miscompares++; $display("FAIL sat_ovf: got %0d want %0d", ovf, exp_ovf); end
    drain(10);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL sat_len: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL sat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w;
    ready = 1'b0;
    send_frame(DW'($urandom));
    for (int c = 0; c < 8; c++) drive(1'b0, 1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    exp_ovf = 0;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    vectors++; if (data !== '0) begin miscompares++; $display("FAIL rstmid_data: got %h want 0000", data); end
    vectors++; if (ovf !== 8'd0) begin miscompares++; $display("FAIL rstmid_ovf: got %0d want 0", ovf); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rstmid_state: got %0d want 0", state); end
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    ready = 1'b1;
    w = DW'($urandom);
    repeat (6) drive(1'b0, 1'($urandom_range(0, 1)));
    send_half(1'b1, DW'($urandom), DW, 20);
    send_frame(w);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== w) begin
      miscompares++; $display("FAIL rstmid_recover: got %0d words want 1 (%h)", got_q.size(), w);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    lrck   = 1'b1;
    dat    = 1'b0;
    ready  = 1'b0;
`ifdef LEVEL_METER_EN
    peak_clr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_hold_random();
    test_push_pop_full();
    test_disable();
    test_short_frame();
    test_random();
`ifdef LEVEL_METER_EN
    test_peak();
`endif
    test_saturate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_capture_fifo.md
Name: i2s_capture_fifo

Overview:
- Audio capture front end between the codec ADC serial pins and the SRAM record writer.
- Deserialises one channel of the codec's I2S stream (ADCLRCK/ADCDAT) on BCLK into 16-bit two's-complement samples.
- Buffers samples in a small show-ahead FIFO and hands them downstream with a valid/ready handshake.
- Counts samples dropped on overflow so the recorder can flag gaps.

Parameters:
- DATA_W, 16, sample width in bits (MSB first on the wire).
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- CHANNEL, 0, captured channel: 0 = left (LRCK low), 1 = right (LRCK high).

Ports:
- i_clk  input  1  BCLK; all logic on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  capture enable (level).
- i_ADCLRCK  input  1  codec LR clock, synchronous to i_clk.
- i_ADCDAT  input  1  codec serial data.
- o_data  output  DATA_W  FIFO head sample.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts the head when o_valid & i_ready.
- o_overflow_cnt  output  8  dropped-sample count, saturating.
- o_busy  output  1  high while a sample is being shifted in.
- o_state  output  2  current FSM state encoding, for debug LEDs.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_overflow_cnt=0, o_busy=0, o_state=S_IDLE. FIFO pointers, storage and shift register are cleared. The registered previous-LRCK value is loaded with the current i_ADCLRCK.
- Edge detect: lrck_prev is registered every cycle. The "channel start" edge is the LRCK transition into the CHANNEL level:
  - falling edge for CHANNEL=0;
  - rising edge for CHANNEL=1.
- FSM states, encoded 0..3:
  - S_IDLE: wait for i_enable=1, then go to S_WAIT.
  - S_WAIT: on the channel-start edge go to S_SKIP. This is the cycle where lrck_prev differs from i_ADCLRCK and i_ADCLRCK equals the CHANNEL level.
  - S_SKIP: one-bit I2S delay; ignore ADCDAT for one cycle, clear the bit counter, go to S_SHIFT.
  - S_SHIFT: shift i_ADCDAT into the LSB each cycle for DATA_W cycles, MSB first. On the DATA_W-th bit, raise an internal push pulse and go to S_WAIT. No new sample starts before the next channel-start edge, so the opposite channel is ignored.
- o_busy = 1 in S_SKIP and S_SHIFT.
- i_enable=0 in any state:
  - next state is S_IDLE and any partial sample is discarded;
  - FIFO contents and o_overflow_cnt are retained;
  - the consumer can still drain the FIFO.
- LRCK edge while in S_SHIFT before DATA_W bits (short frame): abort, discard the partial sample, go to S_WAIT. If that edge is itself a channel-start edge, go directly to S_SKIP.
- Latency: the LSB is captured at edge N. The FIFO write happens at edge N+1. o_valid is high after edge N+1, with o_data equal to the sample if the FIFO was empty.
- FIFO, show-ahead:
  - o_data = storage[rd_ptr];
  - pop when o_valid & i_ready;
  - push when the push pulse fires and (not full or pop in the same cycle).
- Full with push and no pop: the new sample is dropped and o_overflow_cnt increments, saturating at 255.
- Full with push and pop in the same cycle: both occur and there is no overflow.
- Empty: o_valid=0 and i_ready is ignored. o_data shows storage at rd_ptr, which is stale and must not be consumed.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Wrap-around is modulo 2·FIFO_DEPTH.
- Reset mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro: LEVEL_METER_EN.
- When defined, the block adds:
  - output o_peak (DATA_W−1 bits);
  - input i_peak_clr (1 bit).
- o_peak holds the maximum absolute value of all samples pushed since the last clear. The most negative value (-32768 at 16 bits) saturates to 32767. o_peak is updated at the FIFO-write edge. Overflow-dropped samples are still included.
- i_peak_clr sets o_peak to 0. If a clear coincides with a push, the clear wins and that sample is ignored.
- Reset value of o_peak is 0.
- When not defined, neither port exists and no peak logic is built.

Test Plan:
- Basic capture: CHANNEL=0, i_enable=1, i_ready=1. Send a left word 0xA5C3 (one skip bit, then MSB first) and a right word 0xFFFF. Expected: exactly one transfer with o_data=0xA5C3, o_valid high for exactly one cycle, starting the edge after the LSB.
- Overflow: i_ready=0, send 6 left frames 0x0001..0x0006 with FIFO_DEPTH=4. Expected: o_overflow_cnt=2. After raising i_ready, pops return 0x0001..0x0004 in order, then o_valid=0.
- Simultaneous push/pop on full: FIFO holds 4 samples; assert i_ready on the cycle the 5th sample's push fires. Expected: o_overflow_cnt unchanged and the 5th sample is delivered after the first four.
- Disable mid-frame: drop i_enable after 7 bits of a frame. Expected: no push and state back to S_IDLE (o_state=0). Re-enable mid-frame: nothing is captured until the next falling LRCK edge, then the next full word is received correctly.
- Short frame: toggle LRCK after 10 data bits. Expected: partial sample discarded, o_valid stays 0, and the next full frame is captured correctly.
- LEVEL_METER_EN: push 0x1234, 0x8000, 0x0100. Expected: o_peak=0x7FFF. Pulse i_peak_clr, then push 0xFF00. Expected: o_peak=0x0100.
